// File: rtl/if_stage_reg.sv
// Fetch stage: PC register, instruction-memory request and IF/ID pipeline register.
// Handles redirects from the next-PC mux, hazard stalls and memory wait states.
// Also keeps sticky misalignment status and debug counters for fetches and flushes.
//
// state | meaning
// ------+-----------------------------------------------------------------
// BOOT  | first cycle out of reset, no request, IF/ID holds a bubble
// FETCH | request pc_if from instruction memory each cycle
// HOLD  | hazard stall, request dropped, pc_if and IF/ID frozen
module if_stage_reg #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] npc,
  input  logic        flush,
  input  logic        stall,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] pc_if,
  output logic [31:0] pc_add4_if,
  output logic [31:0] pc_id,
  output logic [31:0] pc_add4_id,
  output logic [31:0] inst_id,
  output logic        valid_id,
  output logic        misalign,
  output logic [31:0] fetch_cnt,
  output logic [31:0] flush_cnt
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t state;

  // Sequential target fed back to the next-PC mux; the fetch address is the PC itself.
  assign pc_add4_if = pc_if + 32'd4;
  assign imem_addr  = pc_if;

  // Fetch sequencing, PC update, IF/ID register and debug counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= BOOT;
      imem_req   <= 1'b0;
      pc_if      <= PC_RESET;
      pc_id      <= 32'd0;
      pc_add4_id <= 32'd0;
      inst_id    <= NOP_INST;
      valid_id   <= 1'b0;
      misalign   <= 1'b0;
      fetch_cnt  <= 32'd0;
      flush_cnt  <= 32'd0;
    end else begin
      case (state)
        BOOT: begin
          pc_id      <= 32'd0;
          pc_add4_id <= 32'd0;
          inst_id    <= NOP_INST;
          valid_id   <= 1'b0;
          state      <= FETCH;
          imem_req   <= 1'b1;
        end

        FETCH: begin
          if (flush) begin
            // Redirect wins over stall and any data returned this cycle.
            pc_if      <= npc;
            misalign   <= misalign | (npc[1:0] != 2'b00);
            pc_id      <= 32'd0;
            pc_add4_id <= 32'd0;
            inst_id    <= NOP_INST;
            valid_id   <= 1'b0;
            flush_cnt  <= flush_cnt + 32'd1;
          end else if (stall) begin
            // Returned data is dropped; the same PC is re-requested after the stall.
            state    <= HOLD;
            imem_req <= 1'b0;
          end else if (imem_ready) begin
            pc_id      <= pc_if;
            pc_add4_id <= pc_add4_if;
            inst_id    <= imem_rdata;
            valid_id   <= 1'b1;
            pc_if      <= npc;
            misalign   <= misalign | (npc[1:0] != 2'b00);
            fetch_cnt  <= fetch_cnt + 32'd1;
          end else begin
            // Wait state: keep the address stable and feed decode a bubble.
            pc_id      <= 32'd0;
            pc_add4_id <= 32'd0;
            inst_id    <= NOP_INST;
            valid_id   <= 1'b0;
          end
        end

        HOLD: begin
          if (flush) begin
            pc_if      <= npc;
            misalign   <= misalign | (npc[1:0] != 2'b00);
            pc_id      <= 32'd0;
            pc_add4_id <= 32'd0;
            inst_id    <= NOP_INST;
            valid_id   <= 1'b0;
            flush_cnt  <= flush_cnt + 32'd1;
            state      <= FETCH;
            imem_req   <= 1'b1;
          end else if (!stall) begin
            state    <= FETCH;
            imem_req <= 1'b1;
          end
        end

        default: begin
          state    <= BOOT;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_stage_reg.sv
// Testbench for if_stage_reg: directed scenarios plus randomized traffic against a
// behavioural model of the fetch stage.
module tb_if_stage_reg;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] npc = 32'd0;
  logic        flush = 1'b0;
  logic        stall = 1'b0;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic        imem_req;
  logic [31:0] imem_addr, pc_if, pc_add4_if, pc_id, pc_add4_id, inst_id;
  logic        valid_id, misalign;
  logic [31:0] fetch_cnt, flush_cnt;

  int errors = 0;
  int checks = 0;

  if_stage_reg dut (
    .clk(clk), .rst(rst), .npc(npc), .flush(flush), .stall(stall),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .imem_req(imem_req),
    .imem_addr(imem_addr), .pc_if(pc_if), .pc_add4_if(pc_add4_if),
    .pc_id(pc_id), .pc_add4_id(pc_add4_id), .inst_id(inst_id),
    .valid_id(valid_id), .misalign(misalign), .fetch_cnt(fetch_cnt),
    .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: "booting" for one cycle after reset, otherwise either fetching
  // or parked on a stall; the decode slot is a record of the last delivered fetch.
  bit          m_booting, m_parked;
  logic [31:0] m_pc, m_id_pc, m_id_pc4, m_id_inst;
  bit          m_id_valid, m_mis;
  logic [31:0] m_fetches, m_flushes;

  function automatic void m_bubble();
    m_id_pc = 32'd0; m_id_pc4 = 32'd0; m_id_inst = 32'h13; m_id_valid = 1'b0;
  endfunction

  function automatic void m_redirect(logic [31:0] target);
    m_pc = target;
    if (target % 4 != 0) m_mis = 1'b1;
  endfunction

  function automatic void model_step();
    if (rst) begin
      m_booting = 1'b1; m_parked = 1'b0; m_pc = 32'd0; m_bubble();
      m_mis = 1'b0; m_fetches = 32'd0; m_flushes = 32'd0;
    end else if (m_booting) begin
      m_booting = 1'b0; m_bubble();
    end else if (flush) begin
      m_flushes = m_flushes + 1; m_redirect(npc); m_bubble(); m_parked = 1'b0;
    end else if (m_parked) begin
      m_parked = stall;
    end else if (stall) begin
      m_parked = 1'b1;
    end else if (imem_ready) begin
      m_id_pc = m_pc; m_id_pc4 = m_pc + 32'd4; m_id_inst = imem_rdata; m_id_valid = 1'b1;
      m_fetches = m_fetches + 1; m_redirect(npc);
    end else begin
      m_bubble();
    end
  endfunction

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(bit r, bit f, bit s, bit rdy, logic [31:0] n, logic [31:0] d);
    rst = r; flush = f; stall = s; imem_ready = rdy; npc = n; imem_rdata = d;
  endtask

  task automatic test_reset();
    drive(1, 0, 0, 0, 32'h0, 32'h0);
    repeat (3) cycle();
    checks++; if (pc_if !== 32'h0) begin errors++; $display("FAIL reset_pc actual=%h required=%h", pc_if, 32'h0); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req actual=%b required=0", imem_req); end
    checks++; if (inst_id !== 32'h13 || valid_id !== 1'b0) begin errors++; $display("FAIL reset_ifid actual=%h/%b required=00000013/0", inst_id, valid_id); end
    checks++; if (fetch_cnt !== 0 || flush_cnt !== 0 || misalign !== 0) begin errors++; $display("FAIL reset_cnt actual=%0d/%0d/%b required=0/0/0", fetch_cnt, flush_cnt, misalign); end
    drive(0, 1, 0, 1, 32'h44, 32'hDEAD);
    cycle();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || valid_id !== 1'b0) begin errors++; $display("FAIL boot_exit actual=%b/%h/%b required=1/00000000/0", imem_req, imem_addr, valid_id); end
    checks++; if (flush_cnt !== 0) begin errors++; $display("FAIL boot_flush_ignored actual=%0d required=0", flush_cnt); end
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 1, m_pc + 32'd4, 32'hA0 + i);
      cycle();
      checks++; if (inst_id !== 32'hA0 + i || pc_id !== 4 * i || pc_add4_id !== 4 * i + 4 || valid_id !== 1'b1) begin
        errors++; $display("FAIL seq_capture%0d actual=%h/%h/%h/%b required=%h/%h/%h/1", i, inst_id, pc_id, pc_add4_id, valid_id, 32'hA0 + i, 4 * i, 4 * i + 4);
      end
    end
    checks++; if (fetch_cnt !== 4) begin errors++; $display("FAIL seq_fetch_cnt actual=%0d required=4", fetch_cnt); end
    checks++; if (pc_if !== 32'h10 || pc_add4_if !== 32'h14) begin errors++; $display("FAIL seq_pc actual=%h/%h required=00000010/00000014", pc_if, pc_add4_if); end
  endtask

  task automatic test_flush();
    drive(0, 1, 0, 1, 32'h40, 32'hBAD);
    cycle();
    checks++; if (pc_if !== 32'h40 || inst_id !== 32'h13 || valid_id !== 1'b0 || flush_cnt !== 1 || fetch_cnt !== 4) begin
      errors++; $display("FAIL flush_redirect actual=%h/%h/%b/%0d/%0d required=00000040/00000013/0/1/4", pc_if, inst_id, valid_id, flush_cnt, fetch_cnt);
    end
    drive(0, 0, 0, 1, 32'h44, 32'hB0);
    cycle();
    checks++; if (pc_id !== 32'h40 || inst_id !== 32'hB0 || pc_if !== 32'h44) begin errors++; $display("FAIL flush_follow actual=%h/%h/%h required=00000040/000000b0/00000044", pc_id, inst_id, pc_if); end
  endtask

  task automatic test_stall();
    drive(0, 1, 1, 1, 32'h80, 32'hBAD);
    cycle();
    checks++; if (pc_if !== 32'h80 || valid_id !== 1'b0 || imem_req !== 1'b1 || flush_cnt !== 2) begin
      errors++; $display("FAIL stall_flush_prio actual=%h/%b/%b/%0d required=00000080/0/1/2", pc_if, valid_id, imem_req, flush_cnt);
    end
    drive(0, 0, 0, 1, 32'h84, 32'hC0);
    cycle();
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 1, 1, 32'h999, 32'hBAD);
      cycle();
      checks++; if (imem_req !== 1'b0 || pc_if !== 32'h84 || inst_id !== 32'hC0 || pc_id !== 32'h80 || fetch_cnt !== 6) begin
        errors++; $display("FAIL stall_hold%0d actual=%b/%h/%h/%h/%0d required=0/00000084/000000c0/00000080/6", i, imem_req, pc_if, inst_id, pc_id, fetch_cnt);
      end
    end
    drive(0, 0, 0, 0, 32'h999, 32'hBAD);
    cycle();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h84 || inst_id !== 32'hC0 || valid_id !== 1'b1) begin
      errors++; $display("FAIL stall_release actual=%b/%h/%h/%b required=1/00000084/000000c0/1", imem_req, imem_addr, inst_id, valid_id);
    end
  endtask

  task automatic test_wait();
    drive(0, 1, 0, 0, 32'h10, 32'h0);
    cycle();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 32'h777 + i, 32'hBAD);
      cycle();
      checks++; if (imem_addr !== 32'h10 || imem_req !== 1'b1 || valid_id !== 1'b0 || inst_id !== 32'h13 || fetch_cnt !== 6) begin
        errors++; $display("FAIL wait%0d actual=%h/%b/%b/%h/%0d required=00000010/1/0/00000013/6", i, imem_addr, imem_req, valid_id, inst_id, fetch_cnt);
      end
    end
    drive(0, 0, 0, 1, 32'h14, 32'hD0);
    cycle();
    checks++; if (inst_id !== 32'hD0 || pc_id !== 32'h10 || fetch_cnt !== 7 || pc_if !== 32'h14) begin
      errors++; $display("FAIL wait_capture actual=%h/%h/%0d/%h required=000000d0/00000010/7/00000014", inst_id, pc_id, fetch_cnt, pc_if);
    end
  endtask

  task automatic test_reset_mid();
    drive(0, 1, 0, 0, 32'h20, 32'h0);
    cycle();
    drive(0, 0, 0, 0, 32'h24, 32'h0);
    cycle();
    drive(1, 1, 1, 1, 32'h60, 32'hBAD);
    cycle();
    checks++; if (pc_if !== 32'h0 || fetch_cnt !== 0 || flush_cnt !== 0 || imem_req !== 1'b0 || valid_id !== 1'b0) begin
      errors++; $display("FAIL mid_reset actual=%h/%0d/%0d/%b/%b required=00000000/0/0/0/0", pc_if, fetch_cnt, flush_cnt, imem_req, valid_id);
    end
    drive(0, 0, 0, 0, 32'h0, 32'h0);
    cycle();
    drive(0, 1, 0, 0, 32'h2, 32'h0);
    cycle();
    checks++; if (misalign !== 1'b1 || pc_if !== 32'h2 || flush_cnt !== 1) begin errors++; $display("FAIL misalign_set actual=%b/%h/%0d required=1/00000002/1", misalign, pc_if, flush_cnt); end
    drive(0, 0, 0, 1, 32'h8, 32'hE0);
    cycle();
    checks++; if (pc_id !== 32'h2 || pc_add4_id !== 32'h6 || inst_id !== 32'hE0 || misalign !== 1'b1) begin
      errors++; $display("FAIL misalign_fetch actual=%h/%h/%h/%b required=00000002/00000006/000000e0/1", pc_id, pc_add4_id, inst_id, misalign);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      logic [31:0] n;
      n = $urandom;
      if ($urandom_range(0, 15) != 0) n[1:0] = 2'b00;
      if ($urandom_range(0, 3) == 0) n = 32'hFFFF_FFFC;
      drive($urandom_range(0, 49) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0,
            $urandom_range(0, 2) != 0, n, $urandom);
      cycle();
      checks++; if (imem_req !== !(m_booting || m_parked) || imem_addr !== m_pc || pc_if !== m_pc || pc_add4_if !== m_pc + 32'd4) begin
        errors++; $display("FAIL rnd_fetch%0d actual=%b/%h/%h required=%b/%h/%h", i, imem_req, pc_if, pc_add4_if, !(m_booting || m_parked), m_pc, m_pc + 32'd4);
      end
      checks++; if (pc_id !== m_id_pc || pc_add4_id !== m_id_pc4 || inst_id !== m_id_inst || valid_id !== m_id_valid) begin
        errors++; $display("FAIL rnd_ifid%0d actual=%h/%h/%h/%b required=%h/%h/%h/%b", i, pc_id, pc_add4_id, inst_id, valid_id, m_id_pc, m_id_pc4, m_id_inst, m_id_valid);
      end
      checks++; if (misalign !== m_mis || fetch_cnt !== m_fetches || flush_cnt !== m_flushes) begin
        errors++; $display("FAIL rnd_status%0d actual=%b/%0d/%0d required=%b/%0d/%0d", i, misalign, fetch_cnt, flush_cnt, m_mis, m_fetches, m_flushes);
      end
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_sequential();
    test_flush();
    test_stall();
    test_wait();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
